// File: rtl/bank_group_sched.sv
// bank_group_sched: per-bank-group command sequencer with open-row tracking, tRP/tRCD waits and BL-beat bursts.
// Define BG_CLOSE_PAGE_EN to precharge after every burst (close-page policy); open-page otherwise.
module bank_group_sched #(
   parameter int BAWIDTH      = 2,
   parameter int ADDRWIDTH    = 17,
   parameter int COLWIDTH     = 10,
   parameter int DEVICE_WIDTH = 4,
   parameter int BL           = 8,
   parameter int TRCD         = 4,
   parameter int TRP          = 4,
   parameter int RDLAT        = 1,
   localparam int BANKSPERGROUP = 2**BAWIDTH
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          req_valid,
   output logic                                          req_ready,
   input  logic                                          req_wr,
   input  logic [BAWIDTH-1:0]                            req_bank,
   input  logic [ADDRWIDTH-1:0]                          req_row,
   input  logic [COLWIDTH-1:0]                           req_col,
   output logic                                          wdata_req,
   input  logic [DEVICE_WIDTH-1:0]                       wdata,
   output logic                                          rdata_valid,
   output logic [DEVICE_WIDTH-1:0]                       rdata,
   output logic                                          busy,
   output logic [BANKSPERGROUP-1:0][0:0]                 bg_rd_o_wr,
   output logic [BANKSPERGROUP-1:0][ADDRWIDTH-1:0]       bg_row,
   output logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]        bg_column,
   output logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]    bg_dqin,
   input  logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]    bg_dqout
);
   localparam int BW = $clog2(BL);
   localparam int CW = $clog2((TRCD > TRP ? TRCD : TRP) + 1);
   localparam logic [COLWIDTH-1:0] MASK = COLWIDTH'(BL - 1);
   localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, ACT = 2'd2, BURST = 2'd3;

   logic [1:0]                                    state;
   logic [CW-1:0]                                 cnt;
   logic [BW-1:0]                                 beat;
   logic                                          wr;
   logic [BAWIDTH-1:0]                            bank;
   logic [ADDRWIDTH-1:0]                          row;
   logic [COLWIDTH-1:0]                           col;
   logic [BANKSPERGROUP-1:0]                      open_v;
   logic [BANKSPERGROUP-1:0][ADDRWIDTH-1:0]       open_row;
   logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]        col_q;
   logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]    dqin_q;
   logic [RDLAT-1:0]                              pipe_v;
   logic [RDLAT-1:0][BAWIDTH-1:0]                 pipe_bank;
   logic                                          accept;
   logic                                          last_beat;
   logic [COLWIDTH-1:0]                           cur_col;

   assign req_ready   = rst_n && state == IDLE;
   assign accept      = req_valid && req_ready;
   assign last_beat   = beat == BW'(BL - 1);
   // column wraps inside the BL-aligned block
   assign cur_col     = (col & ~MASK) | ((col + COLWIDTH'(beat)) & MASK);
   assign wdata_req   = state == BURST && wr;
   assign rdata_valid = pipe_v[RDLAT-1];
   assign rdata       = rdata_valid ? bg_dqout[pipe_bank[RDLAT-1]] : '0;
   assign busy        = state != IDLE || |pipe_v;
   assign bg_row      = open_row;

   always_comb begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
         bg_rd_o_wr[b] = state == BURST && bank == BAWIDTH'(b) && wr;
         bg_column[b]  = state == BURST && bank == BAWIDTH'(b) ? cur_col : col_q[b];
         bg_dqin[b]    = state == BURST && bank == BAWIDTH'(b) && wr ? wdata : dqin_q[b];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         beat      <= '0;
         wr        <= 1'b0;
         bank      <= '0;
         row       <= '0;
         col       <= '0;
         open_v    <= '0;
         open_row  <= '0;
         col_q     <= '0;
         dqin_q    <= '0;
         pipe_v    <= '0;
         pipe_bank <= '0;
      end else begin
         // read capture follows the bank that issued the beat, not the current request
         pipe_v[0]    <= state == BURST && !wr;
         pipe_bank[0] <= bank;
         for (int i = 1; i < RDLAT; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_bank[i] <= pipe_bank[i-1];
         end
         case (state)
            IDLE: if (accept) begin
               wr   <= req_wr;
               bank <= req_bank;
               row  <= req_row;
               col  <= req_col;
               beat <= '0;
               if (open_v[req_bank] && open_row[req_bank] == req_row) state <= BURST;
               else if (open_v[req_bank]) begin
                  state            <= PRE;
                  cnt              <= CW'(TRP - 1);
                  open_v[req_bank] <= 1'b0;
               end else begin
                  state              <= ACT;
                  cnt                <= CW'(TRCD - 1);
                  open_v[req_bank]   <= 1'b1;
                  open_row[req_bank] <= req_row;
               end
            end
            PRE: if (cnt == '0) begin
`ifdef BG_CLOSE_PAGE_EN
               state <= IDLE;
`else
               state          <= ACT;
               cnt            <= CW'(TRCD - 1);
               open_v[bank]   <= 1'b1;
               open_row[bank] <= row;
`endif
            end else cnt <= cnt - CW'(1);
            ACT: if (cnt == '0) state <= BURST;
               else cnt <= cnt - CW'(1);
            BURST: begin
               col_q[bank] <= cur_col;
               if (wr) dqin_q[bank] <= wdata;
               beat <= beat + BW'(1);
               if (last_beat) begin
`ifdef BG_CLOSE_PAGE_EN
                  state        <= PRE;
                  cnt          <= CW'(TRP - 1);
                  open_v[bank] <= 1'b0;
`else
                  state <= IDLE;
`endif
               end
            end
         endcase
      end
   end
endmodule
